// File: rtl/memory_round_ctrl_pkg.sv
// Shared definitions for the digit-memory round controller: FSM states,
// default sequence increment and the nibble/level helper functions.
package memory_round_ctrl_pkg;

  localparam logic [19:0] STEP_DEFAULT = 20'hC9A4F;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_SHOW  = 3'd2,
    ST_GAP   = 3'd3,
    ST_INPUT = 3'd4,
    ST_PASS  = 3'd5,
    ST_FAIL  = 3'd6
  } state_e;

  // Folds a hex nibble onto 0..9 so every sequence value is a keypad digit.
  function automatic logic [3:0] map_digit(input logic [3:0] h);
    return (h < 4'd10) ? h : h - 4'd6;
  endfunction

  function automatic logic [3:0] level_len(input logic [1:0] lv);
    return 4'd4 + {1'b0, lv, 1'b0};
  endfunction

endpackage

// File: rtl/memory_round_ctrl_if.sv
// Round-controller bus: random seed source, level select, keypad strobe
// and the display / result signals returned to the game top level.
interface memory_round_ctrl_if;
  logic [19:0] count_in;
  logic        level_go;
  logic [1:0]  level;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        busy;
  logic        disp_en;
  logic [3:0]  disp_digit;
  logic [3:0]  digit_idx;
  logic        expect_input;
  logic        result_valid;
  logic        result_pass;

  modport master (
    output count_in, level_go, level, key_valid, key_code,
    input  busy, disp_en, disp_digit, digit_idx, expect_input,
           result_valid, result_pass
  );

  modport slave (
    input  count_in, level_go, level, key_valid, key_code,
    output busy, disp_en, disp_digit, digit_idx, expect_input,
           result_valid, result_pass
  );
endinterface

// File: rtl/memory_round_ctrl_seq_digit_gen.sv
// Sequence state s(k): reloaded from the seed or stepped by STEP, with the
// current value mapped combinationally to a decimal digit.
module memory_round_ctrl_seq_digit_gen
  import memory_round_ctrl_pkg::*;
#(
  parameter logic [19:0] STEP = STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  input  logic [19:0] seed,
  output logic [3:0]  digit
);

  logic [19:0] s_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst)          s_q <= '0;
    else if (load)    s_q <= seed;
    else if (advance) s_q <= s_q + STEP;
  end

  assign digit = map_digit(s_q[19:16]);

endmodule

// File: rtl/memory_round_ctrl.sv
// One round of the digit-memory game: capture seed, show the sequence,
// then check keypad entries against a replay of it and report pass/fail.
module memory_round_ctrl
  import memory_round_ctrl_pkg::*;
#(
  parameter logic [19:0] STEP     = STEP_DEFAULT,
  parameter int unsigned SHOW_CYC = 25000000,
  parameter int unsigned GAP_CYC  = 5000000,
  parameter int unsigned TMO_CYC  = 250000000
) (
  input  logic               clk,
  input  logic               keypad_0,
  memory_round_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] SEED  = ST_SEED;
  localparam logic [2:0] SHOW  = ST_SHOW;
  localparam logic [2:0] GAP   = ST_GAP;
  localparam logic [2:0] INPUT = ST_INPUT;
  localparam logic [2:0] PASS  = ST_PASS;
  localparam logic [2:0] FAIL  = ST_FAIL;

  localparam logic [31:0] SHOW_LAST = 32'(SHOW_CYC - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYC - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TMO_CYC - 1);

  logic [2:0]  state_q, state_d;
  logic [19:0] seed_q, seed_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] timer_q, timer_d;
  logic        pass_q, pass_d;
  logic        seq_load, seq_adv;
  logic [3:0]  digit;
  logic        idx_last;

  memory_round_ctrl_seq_digit_gen #(.STEP(STEP)) u_seq (
    .clk     (clk),
    .rst     (keypad_0),
    .load    (seq_load),
    .advance (seq_adv),
    .seed    (seed_q),
    .digit   (digit)
  );

  assign idx_last = (idx_q == len_q - 4'd1);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    len_d    = len_q;
    idx_d    = idx_q;
    timer_d  = '0;
    pass_d   = pass_q;
    seq_load = 1'b0;
    seq_adv  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.level_go) begin
          seed_d  = bus.count_in;
          len_d   = level_len(bus.level);
          pass_d  = 1'b0;
          state_d = SEED;
        end
      end
      SEED: begin
        seq_load = 1'b1;
        idx_d    = '0;
        state_d  = SHOW;
      end
      SHOW: begin
        timer_d = timer_q + 32'd1;
        if (timer_q == SHOW_LAST) begin
          timer_d = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        timer_d = timer_q + 32'd1;
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          if (!idx_last) begin
            idx_d   = idx_q + 4'd1;
            seq_adv = 1'b1;
            state_d = SHOW;
          end else begin
            // Rewind to s0 so the replay checks keys against the same digits.
            idx_d    = '0;
            seq_load = 1'b1;
            state_d  = INPUT;
          end
        end
      end
      INPUT: begin
        timer_d = timer_q + 32'd1;
        // A key arriving on the expiry cycle takes priority over the timeout.
        if (bus.key_valid) begin
          if (bus.key_code <= 4'd9 && bus.key_code == digit) begin
            if (idx_last) begin
              pass_d  = 1'b1;
              state_d = PASS;
            end else begin
              idx_d   = idx_q + 4'd1;
              seq_adv = 1'b1;
              timer_d = '0;
            end
          end else begin
            state_d = FAIL;
          end
        end else if (timer_q == TMO_LAST) begin
          state_d = FAIL;
        end
      end
      PASS, FAIL: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (keypad_0) begin
      state_q <= IDLE;
      seed_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.disp_en      = (state_q == SHOW);
  assign bus.disp_digit   = (state_q == SHOW) ? digit : 4'd0;
  assign bus.digit_idx    = idx_q;
  assign bus.expect_input = (state_q == INPUT);
  assign bus.result_valid = (state_q == PASS) || (state_q == FAIL);
  assign bus.result_pass  = pass_q;

endmodule

// File: doc/memory_round_ctrl.md
Name: memory_round_ctrl

Overview:
- Sequences one round of the digit-memory game.
- On a level-select event it captures the free-running 20-bit random counter value as a seed.
- From that seed it derives a digit sequence whose length depends on the level, and drives the display one digit at a time.
- It then replays the same sequence internally to check the player's keypad entries, and reports pass/fail to the top-level game FSM.

Parameters:
- STEP, 20'hC9A4F, odd sequence increment (coprime with 2^20).
- SHOW_CYC, 25000000, cycles each digit is displayed.
- GAP_CYC, 5000000, blank cycles after each digit.
- TMO_CYC, 250000000, input timeout between accepted keys.

Ports:
- clk  in  1  system clock
- keypad_0  in  1  reset, synchronous, active-high
- count_in  in  20  free-running random counter value
- level_go  in  1  one-cycle level-select strobe
- level  in  2  selected level, 0..3
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  4  pressed key value
- busy  out  1  high in every state except IDLE
- disp_en  out  1  high while a digit is shown
- disp_digit  out  4  digit to show; 0 when disp_en=0
- digit_idx  out  4  current sequence position
- expect_input  out  1  high in INPUT
- result_valid  out  1  one-cycle pulse at round end
- result_pass  out  1  valid with result_valid; held until next round start

Behaviour:
- Reset (keypad_0=1 at a clk edge): state=IDLE; all outputs 0; seed, timers and idx=0. Applies mid-round as well; the round is abandoned with no result pulse.
- Sequence definition:
  - Length N = 4 + 2*level (4/6/8/10).
  - s0 = seed; s(k+1) = (s(k) + STEP) mod 2^20.
  - digit(k) = h if h<10, else h-6, where h = s(k)[19:16].
- IDLE:
  - level_go=1 → seed<=count_in, N latched from level, result_pass<=0, next state SEED.
  - level_go outside IDLE is ignored.
- SEED (1 cycle): s<=seed, idx<=0 → SHOW.
- SHOW:
  - disp_en=1, disp_digit=digit(idx), for exactly SHOW_CYC cycles → GAP.
- GAP:
  - disp_en=0 for exactly GAP_CYC cycles.
  - If idx<N-1: idx++, s advances → SHOW.
  - Else: s<=seed, idx<=0, timer cleared → INPUT.
- INPUT (expect_input=1):
  - key_valid with key_code==digit(idx): if idx==N-1 → PASS; else idx++, s advances, timer cleared.
  - key_valid with mismatch, or key_code>9 → FAIL.
  - Timer reaches TMO_CYC-1 with no key → FAIL. key_valid in the same cycle as expiry is processed; the timeout loses.
- PASS/FAIL (1 cycle): result_valid=1, result_pass=1/0 → IDLE.
- Key strobes in IDLE/SEED/SHOW/GAP are ignored.
- Latency: level_go at cycle t → first digit visible at t+2.
- All arithmetic wraps at 20 bits. Timers are 32-bit and saturate-free (cleared on state entry).

Decomposition:
- Shared package:
  - state enum (IDLE, SEED, SHOW, GAP, INPUT, PASS, FAIL)
  - STEP default
  - digit-map function (nibble→0..9)
  - level→length function
- Sub-module seq_digit_gen:
  - holds s
  - load (from seed) / advance (add STEP) controls
  - outputs the mapped digit combinationally
- The controller owns the FSM, timers and idx.

Test Plan (SHOW_CYC=3, GAP_CYC=2, TMO_CYC=20):
- count_in=0, level=0, level_go at cycle 0 → SEED at 1; disp_en high for cycles 2-4, 7-9, 12-14, 17-19, showing 0,6,9,5 in that order; expect_input rises at cycle 22.
- Same round, keys 0,6,9,5 entered in INPUT → result_valid pulses 1 cycle after the key 5 cycle, with result_pass=1; busy=0 the next cycle.
- Same round, keys 0,7 entered → FAIL on key 7: result_valid=1, result_pass=0; idx never exceeds 1.
- INPUT entered, key 0 accepted, then no key for 20 cycles → FAIL pulse; then key_valid with timeout expiry in the same cycle and correct digit → accepted, no FAIL.
- keypad_0 asserted during SHOW (cycle 8) → next cycle IDLE with all outputs 0 and no result_valid; level_go during SHOW/INPUT has no effect.
- level=3 (N=10) and key_code=4'hA entered in INPUT → 10 digits shown, then an immediate FAIL on the invalid code.
